hls_saturation_enhance_mix: RTL and testbench
=============================================

HLS_SATURATION_ENHANCE_MIX -- requirements
Module: hls_saturation_enhance_mix

Interface
- REQ-001: The block SHALL have parameter GAIN_FRAC, default 7: number of fractional bits in the gain.
- REQ-002: The block SHALL have parameter RESET_GAIN, default 128: gain value loaded at reset (unity).
- REQ-003: The block SHALL have port ap_clk, input, 1 bit: the single clock; all logic is on the rising edge.
- REQ-004: The block SHALL have port ap_rst, input, 1 bit: reset, synchronous and active-high.
- REQ-005: The block SHALL have port s_axis_tdata, input, 24 bits: input pixel; [23:16]=R, [15:8]=G, [7:0]=B.
- REQ-006: The block SHALL have ports s_axis_tvalid (in, 1), s_axis_tready (out, 1), s_axis_tuser (in, 1, start of frame) and s_axis_tlast (in, 1, end of line).
- REQ-007: The block SHALL have ports m_axis_tdata (out, 24), m_axis_tvalid (out, 1), m_axis_tready (in, 1), m_axis_tuser (out, 1) and m_axis_tlast (out, 1), with the same channel packing as the input.
- REQ-008: The block SHALL have port gain, input, 8 bits: unsigned saturation gain, Q1.7.
- REQ-009: The block SHALL have port bypass, input, 1 bit: when 1, pixels pass through unmodified.
- REQ-010: The block SHALL have port clip_count, output, 16 bits: number of clamped channels in the previous frame.

Function
- REQ-011: Transfers SHALL follow AXI4-Stream rules: a beat moves when tvalid and tready are both 1; m_axis_tvalid is never withdrawn, nor m_axis data changed, before acceptance.
- REQ-012: The pipeline SHALL have 4 register stages (S1..S4) with a global enable en = !S4_valid | m_axis_tready; s_axis_tready = en.
- REQ-013: Latency SHALL be 4 cycles from input acceptance to m_axis_tvalid when m_axis_tready stays 1; sustained throughput is 1 pixel per clock.
- REQ-014: When en = 0, all stages SHALL hold their contents; no beat is dropped or duplicated.
- REQ-015: tuser, tlast and bypass SHALL travel with the pixel through all 4 stages.
- REQ-016: The gain in use (gain_act) SHALL be captured from the gain port on any accepted input beat with tuser = 1; that beat and all later beats use the new value.
- REQ-017: S1 SHALL compute luma Y = (77R + 150G + 29B + 128) >> 8, an 8-bit unsigned value (sum is at most 65408, so it cannot overflow).
- REQ-018: S2 SHALL compute, per channel, d = c - Y as a 9-bit signed value, split into an 8-bit magnitude |d| and a sign bit.
- REQ-019: S3 SHALL compute p = |d| * gain_act as a 16-bit unsigned product.
- REQ-020: S4 SHALL compute off = (p + 2^(GAIN_FRAC-1)) >> GAIN_FRAC, then r = Y + off or Y - off according to the sign, in a signed 11-bit result.
- REQ-021: r SHALL be clamped to 0..255: r < 0 gives 0, r > 255 gives 255.
- REQ-022: A clamp SHALL count only when r is actually out of range; r = 0 or r = 255 exactly is not a clip.
- REQ-023: A pixel whose bypass bit is 1 SHALL leave with the original c on all channels, with no clip counted and the same latency.
- REQ-024: An internal clip counter SHALL add 0..3 per output beat (one per clamped channel) and saturate at 0xFFFF.
- REQ-025: When an output beat with tuser = 1 is accepted, clip_count SHALL take the counter value accumulated before that beat; the counter then restarts with that beat's own clips.
- REQ-026: If input and output handshakes occur in the same cycle, both SHALL complete.

Reset
- REQ-027: While ap_rst = 1 the block SHALL clear all stage valid bits, so that m_axis_tvalid = 0, m_axis_tdata = 0, m_axis_tuser = 0 and m_axis_tlast = 0.
- REQ-028: Reset SHALL set s_axis_tready = 1 (en = 1 because S4 is empty), gain_act = RESET_GAIN, the clip counter = 0 and clip_count = 0.
- REQ-029: Reset asserted mid-stream SHALL discard all in-flight pixels; the first beat after reset is treated as new data with gain_act = RESET_GAIN unless it carries tuser = 1.

Verification
- REQ-030: Unity gain: gain = 128 on an SOF beat, pixel (200,100,50) -> Y = 124, output (200,100,50) after 4 cycles, no clips.
- REQ-031: High gain: gain = 255 on SOF, pixel (200,100,50) -> output (255,76,0), 2 clips; the next SOF beat accepted at the output gives clip_count = 2.
- REQ-032: Zero gain: gain = 0 on SOF, pixel (200,100,50) -> output (124,124,124).
- REQ-033: Backpressure: stream 16 pixels while toggling m_axis_tready randomly -> output order and values match the model, no loss or duplication, tuser and tlast stay aligned.
- REQ-034: Gain changed on a non-SOF beat -> no effect until the next tuser = 1 beat; bypass = 1 -> output equals input exactly.
- REQ-035: Reset asserted with 3 pixels in flight -> m_axis_tvalid = 0 the next cycle, clip_count = 0, gain_act = 128.

Source files
------------

// File: rtl/hls_saturation_enhance_mix.sv
// Saturation enhancement: each channel is pushed away from (or pulled toward) luma
// by a Q1.7 gain, clamped to 8 bits, with a per-frame count of clamped channels.
module hls_saturation_enhance_mix #(
    parameter int unsigned GAIN_FRAC  = 7,
    parameter int unsigned RESET_GAIN = 128
) (
    input  logic        ap_clk,
    input  logic        ap_rst,
    input  logic [23:0] s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic        s_axis_tuser,
    input  logic        s_axis_tlast,
    output logic [23:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tuser,
    output logic        m_axis_tlast,
    input  logic [7:0]  gain,
    input  logic        bypass,
    output logic [15:0] clip_count
);

    localparam logic [16:0] ROUND = 17'(1) << (GAIN_FRAC - 1);

    logic en;

    // Sideband per stage: {user, last, bypass}
    logic            s1_vld_q, s2_vld_q, s3_vld_q, s4_vld_q;
    logic [2:0]      s1_sb_q, s2_sb_q, s3_sb_q;
    logic [2:0][7:0] s1_pix_q, s2_pix_q, s3_pix_q;
    logic [7:0]      s1_y_q, s2_y_q, s3_y_q;
    logic [7:0]      s1_gain_q, s2_gain_q;
    logic [2:0][7:0] s2_mag_q;
    logic [2:0]      s2_neg_q, s3_neg_q;
    logic [2:0][15:0] s3_prod_q;
    logic [2:0][7:0] s4_data_q;
    logic [1:0]      s4_clips_q;
    logic            s4_user_q, s4_last_q;

    logic [7:0]  gain_act_q, gain_act_d;
    logic [15:0] clip_acc_q, clip_acc_d;
    logic [15:0] clip_count_q, clip_count_d;

    logic [7:0]       y_d, gain_d;
    logic [8:0]       diff;
    logic [2:0][7:0]  mag_d;
    logic [2:0]       neg_d;
    logic [2:0][15:0] prod_d;
    logic [16:0]      off;
    logic [17:0]      r;
    logic             lo, hi;
    logic [2:0][7:0]  data_d;
    logic [1:0]       clips_d;
    logic [16:0]      acc_sum;

    assign en            = !s4_vld_q || m_axis_tready;
    assign s_axis_tready = en;
    assign m_axis_tvalid = s4_vld_q;
    assign m_axis_tdata  = s4_data_q;
    assign m_axis_tuser  = s4_user_q;
    assign m_axis_tlast  = s4_last_q;
    assign clip_count    = clip_count_q;

    // S1: luma, and the gain this beat will use (an SOF beat uses its own gain)
    always_comb begin
        y_d = 8'((16'd77 * 16'(s_axis_tdata[23:16]) + 16'd150 * 16'(s_axis_tdata[15:8])
                 + 16'd29 * 16'(s_axis_tdata[7:0]) + 16'd128) >> 8);
        gain_d     = s_axis_tuser ? gain : gain_act_q;
        gain_act_d = (s_axis_tvalid && en && s_axis_tuser) ? gain : gain_act_q;
    end

    // S2: signed difference to luma as sign + magnitude
    always_comb begin
        diff  = '0;
        mag_d = '0;
        neg_d = '0;
        for (int unsigned i = 0; i < 3; i++) begin
            diff           = {1'b0, s1_pix_q[i[1:0]]} - {1'b0, s1_y_q};
            neg_d[i[1:0]]  = diff[8];
            mag_d[i[1:0]]  = diff[8] ? 8'(-diff) : diff[7:0];
        end
    end

    // S3: magnitude times gain
    always_comb begin
        prod_d = '0;
        for (int unsigned i = 0; i < 3; i++)
            prod_d[i[1:0]] = 16'(s2_mag_q[i[1:0]]) * 16'(s2_gain_q);
    end

    // S4: rounded offset applied to luma, clamp; r is wide enough that bit 17 is the sign
    always_comb begin
        off     = '0;
        r       = '0;
        lo      = 1'b0;
        hi      = 1'b0;
        data_d  = '0;
        clips_d = '0;
        for (int unsigned i = 0; i < 3; i++) begin
            off = (17'(s3_prod_q[i[1:0]]) + ROUND) >> GAIN_FRAC;
            r   = s3_neg_q[i[1:0]] ? 18'(s3_y_q) - 18'(off) : 18'(s3_y_q) + 18'(off);
            lo  = r[17];
            hi  = !r[17] && (r[16:8] != '0);
            data_d[i[1:0]] = lo ? 8'd0 : (hi ? 8'd255 : r[7:0]);
            clips_d = clips_d + {1'b0, lo || hi};
        end
        if (s3_sb_q[0]) begin
            data_d  = s3_pix_q;
            clips_d = '0;
        end
    end

    // Clip accounting on accepted output beats; an SOF beat publishes the previous frame
    always_comb begin
        acc_sum      = 17'(clip_acc_q) + 17'(s4_clips_q);
        clip_acc_d   = clip_acc_q;
        clip_count_d = clip_count_q;
        if (s4_vld_q && m_axis_tready) begin
            if (s4_user_q) begin
                clip_count_d = clip_acc_q;
                clip_acc_d   = 16'(s4_clips_q);
            end else begin
                clip_acc_d = acc_sum[16] ? '1 : acc_sum[15:0];
            end
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            s1_vld_q <= 1'b0; s2_vld_q <= 1'b0; s3_vld_q <= 1'b0; s4_vld_q <= 1'b0;
            s1_sb_q  <= '0;   s2_sb_q  <= '0;   s3_sb_q  <= '0;
            s1_pix_q <= '0;   s2_pix_q <= '0;   s3_pix_q <= '0;
            s1_y_q   <= '0;   s2_y_q   <= '0;   s3_y_q   <= '0;
            s1_gain_q <= '0;  s2_gain_q <= '0;
            s2_mag_q <= '0;   s2_neg_q <= '0;   s3_neg_q <= '0;
            s3_prod_q <= '0;
            s4_data_q <= '0;  s4_clips_q <= '0; s4_user_q <= 1'b0; s4_last_q <= 1'b0;
            gain_act_q   <= 8'(RESET_GAIN);
            clip_acc_q   <= '0;
            clip_count_q <= '0;
        end else begin
            gain_act_q   <= gain_act_d;
            clip_acc_q   <= clip_acc_d;
            clip_count_q <= clip_count_d;
            if (en) begin
                s1_vld_q  <= s_axis_tvalid;
                s1_sb_q   <= {s_axis_tuser, s_axis_tlast, bypass};
                s1_pix_q  <= s_axis_tdata;
                s1_y_q    <= y_d;
                s1_gain_q <= gain_d;

                s2_vld_q  <= s1_vld_q;
                s2_sb_q   <= s1_sb_q;
                s2_pix_q  <= s1_pix_q;
                s2_y_q    <= s1_y_q;
                s2_gain_q <= s1_gain_q;
                s2_mag_q  <= mag_d;
                s2_neg_q  <= neg_d;

                s3_vld_q  <= s2_vld_q;
                s3_sb_q   <= s2_sb_q;
                s3_pix_q  <= s2_pix_q;
                s3_y_q    <= s2_y_q;
                s3_neg_q  <= s2_neg_q;
                s3_prod_q <= prod_d;

                s4_vld_q   <= s3_vld_q;
                s4_user_q  <= s3_sb_q[2];
                s4_last_q  <= s3_sb_q[1];
                s4_data_q  <= data_d;
                s4_clips_q <= clips_d;
            end
        end
    end

endmodule

// File: tb/tb_hls_saturation_enhance_mix.sv
// Scoreboard bench for hls_saturation_enhance_mix: the driver queues hand-computed
// expected beats, a negedge monitor pops and compares them as the DUT emits output.
module tb_hls_saturation_enhance_mix;

    logic        ap_clk = 1'b0;
    logic        ap_rst = 1'b1;
    logic [23:0] s_data = '0;
    logic        s_valid = 1'b0, s_user = 1'b0, s_last = 1'b0;
    logic        s_ready;
    logic [23:0] m_data;
    logic        m_valid, m_user, m_last;
    logic        m_ready = 1'b1;
    logic [7:0]  gain = 8'd128;
    logic        byp = 1'b0;
    logic [15:0] clip_count;

    hls_saturation_enhance_mix #(.GAIN_FRAC(7), .RESET_GAIN(128)) dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst),
        .s_axis_tdata(s_data), .s_axis_tvalid(s_valid), .s_axis_tready(s_ready),
        .s_axis_tuser(s_user), .s_axis_tlast(s_last),
        .m_axis_tdata(m_data), .m_axis_tvalid(m_valid), .m_axis_tready(m_ready),
        .m_axis_tuser(m_user), .m_axis_tlast(m_last),
        .gain(gain), .bypass(byp), .clip_count(clip_count)
    );

    always #5 ap_clk = ~ap_clk;

    typedef struct {
        logic [23:0] data;
        logic        user;
        logic        last;
        bit          chk_clip;
        logic [15:0] clip;
        bit          chk_lat;
        int          acc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   bp_en = 1'b0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", nm, act, req);
        end
    endfunction

    always @(posedge ap_clk) cyc <= cyc + 1;

    always begin
        @(posedge ap_clk);
        #1;
        m_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor
    exp_t        e;
    bit          clip_pend = 1'b0;
    logic [15:0] clip_pend_val = '0;
    bit          prev_stall = 1'b0;
    logic [25:0] prev_out = '0;

    always @(negedge ap_clk) begin
        if (clip_pend) begin
            chk("clip_count", 32'(clip_count), 32'(clip_pend_val));
            clip_pend = 1'b0;
        end
        if (prev_stall)
            chk("stall_hold", 32'({m_valid, m_user, m_last, m_data}), 32'({1'b1, prev_out}));
        if (m_valid && m_ready) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got %h required none", m_data);
            end else begin
                e = q.pop_front();
                chk("tdata", 32'(m_data), 32'(e.data));
                chk("tuser", 32'(m_user), 32'(e.user));
                chk("tlast", 32'(m_last), 32'(e.last));
                if (e.chk_clip) begin
                    clip_pend     = 1'b1;
                    clip_pend_val = e.clip;
                end
                if (e.chk_lat) chk("latency", 32'(cyc - e.acc + 1), 32'd4);
            end
        end
        prev_stall = m_valid && !m_ready;
        prev_out   = {m_user, m_last, m_data};
    end

    task automatic send(input logic [23:0] pix, input logic usr, input logic lst,
                        input logic [7:0] g, input logic b, input logic [23:0] xp,
                        input bit cclip = 1'b0, input logic [15:0] clip = '0,
                        input bit clat = 1'b0);
        exp_t x;
        bit   acc = 1'b0;
        int   n = 0;
        s_data = pix; s_user = usr; s_last = lst; gain = g; byp = b; s_valid = 1'b1;
        while (!acc && n < 1000) begin
            @(negedge ap_clk);
            if (s_ready) begin
                acc = 1'b1;
                x.data = xp; x.user = usr; x.last = lst;
                x.chk_clip = cclip; x.clip = clip; x.chk_lat = clat;
                x.acc = cyc + 1;
                q.push_back(x);
            end
            @(posedge ap_clk);
            #1;
            n++;
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got no s_axis_tready required accept");
        end
    endtask

    task automatic drain();
        int n = 0;
        s_valid = 1'b0;
        while ((q.size() != 0 || clip_pend) && n < 500) begin
            @(negedge ap_clk);
            n++;
        end
        @(negedge ap_clk);
        chk("drain_queue_empty", 32'(q.size()), 32'd0);
        @(posedge ap_clk);
        #1;
    endtask

    function automatic logic [23:0] bp_pix(int i);
        return {8'(i * 16 + 1), 8'(255 - i * 13), 8'(i * 7)};
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1);
    end

    initial begin
        // Reset state
        @(negedge ap_clk);
        chk("rst_tvalid", 32'(m_valid), 32'd0);
        chk("rst_tdata", 32'(m_data), 32'd0);
        chk("rst_tuser", 32'(m_user), 32'd0);
        chk("rst_tlast", 32'(m_last), 32'd0);
        chk("rst_tready", 32'(s_ready), 32'd1);
        chk("rst_clip_count", 32'(clip_count), 32'd0);
        @(posedge ap_clk);
        @(posedge ap_clk);
        #1;
        ap_rst = 1'b0;

        // Unity, high, zero gain on SOF beats; non-SOF gain change; bypass in zero-gain frame
        send(24'hC86432, 1, 1, 8'd128, 0, 24'hC86432, 1, 16'd0, 1);
        send(24'hC86432, 1, 1, 8'd255, 0, 24'hFF4C00, 1, 16'd0);
        send(24'hC86432, 1, 1, 8'd0,   0, 24'h7C7C7C, 1, 16'd2);
        send(24'hC86432, 0, 1, 8'd255, 0, 24'h7C7C7C);
        send(24'h0AFA03, 0, 0, 8'd255, 1, 24'h0AFA03);
        send(24'hC86432, 1, 1, 8'd128, 0, 24'hC86432, 1, 16'd0);

        // High-gain frame: exact 255/0 edges, 3-clip and 2-clip pixels, bypass
        send(24'hFFFFFF, 1, 0, 8'd255, 0, 24'hFFFFFF, 1, 16'd0);
        send(24'h000000, 0, 0, 8'd255, 0, 24'h000000);
        send(24'hFF0000, 0, 0, 8'd255, 0, 24'hFF0000);
        send(24'hC86432, 0, 0, 8'd255, 0, 24'hFF4C00);
        send(24'hC86432, 0, 1, 8'd255, 1, 24'hC86432);
        send(24'h0A141E, 1, 1, 8'd128, 0, 24'h0A141E, 1, 16'd5);
        drain();

        // Backpressure stream at unity gain (output equals input)
        bp_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                s_valid = 1'b0;
                @(posedge ap_clk);
                #1;
            end
            send(bp_pix(i), i == 0, (i % 4) == 3, 8'd128, 0, bp_pix(i), i == 0, 16'd0);
        end
        bp_en = 1'b0;
        drain();

        // Clip counter saturation: 21846 beats x 3 clips exceeds 0xFFFF
        for (int i = 0; i < 21846; i++)
            send(24'hFF0000, i == 0, 0, 8'd255, 0, 24'hFF0000, i == 0, 16'd0);
        send(24'h010203, 1, 1, 8'd128, 0, 24'h010203, 1, 16'hFFFF);
        drain();

        // Reset with 3 pixels in flight (new frame sets gain 255 first)
        send(24'hC86432, 1, 0, 8'd255, 0, 24'hFF4C00);
        send(24'hC86432, 0, 0, 8'd255, 0, 24'hFF4C00);
        send(24'hC86432, 0, 0, 8'd255, 0, 24'hFF4C00);
        s_valid = 1'b0;
        ap_rst  = 1'b1;
        @(posedge ap_clk);
        @(negedge ap_clk);
        chk("midrst_tvalid", 32'(m_valid), 32'd0);
        chk("midrst_tdata", 32'(m_data), 32'd0);
        chk("midrst_clip_count", 32'(clip_count), 32'd0);
        chk("midrst_tready", 32'(s_ready), 32'd1);
        q.delete();
        @(posedge ap_clk);
        #1;
        ap_rst = 1'b0;
        // gain_act must be back to unity: non-SOF beat with gain port 255 stays unchanged
        send(24'hC86432, 0, 1, 8'd255, 0, 24'hC86432);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
